// File: rtl/jar_pi_pkg.sv
// Shared types and constants for the pi digit index controller.
package jar_pi_pkg;

  localparam int INDEX_W = 10;
  localparam int CHUNK_W = 5;
  localparam logic [INDEX_W-1:0] MAX_INDEX = 10'd1023;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    STREAM = 2'd1,
    LOAD1  = 2'd2
  } state_e;

endpackage

// File: rtl/jar_pi_index_ctrl_if.sv
// Control/status bundle between the index controller and its driver.
interface jar_pi_index_ctrl_if #(
  parameter int INDEX_W = 10,
  parameter int CHUNK_W = 5
);
  logic               stream;
  logic               load;
  logic [CHUNK_W-1:0] io_index;
  logic [INDEX_W-1:0] index;
  logic               index_valid;
  logic               load_done;
  logic               wrap;
  logic               busy_load;

  modport master (
    output stream, load, io_index,
    input  index, index_valid, load_done, wrap, busy_load
  );

  modport slave (
    input  stream, load, io_index,
    output index, index_valid, load_done, wrap, busy_load
  );
endinterface

// File: rtl/jar_pi_prescaler.sv
// Step-rate divider: counts enabled cycles and ticks on the last one of each period.
module jar_pi_prescaler #(
  parameter int PRESCALE = 1,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/jar_pi_index_ctrl.sv
// Digit index generator: free-run stream, two-chunk serial load, or hold,
// with registered strobes for new-index, load-complete and wrap.
module jar_pi_index_ctrl
  import jar_pi_pkg::*;
#(
  parameter int INDEX_W  = 10,
  parameter int CHUNK_W  = 5,
  parameter int PRESCALE = 1,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset_n,
  jar_pi_index_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;
  logic               pre_en;
  logic               pre_clr;
  logic               tick;

  jar_pi_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (pre_clr),
    .en      (pre_en),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    pre_en  = 1'b0;
    if (bus.load) begin
      // Chunk enters at the top so the first chunk ends up in the low half.
      index_d = {bus.io_index, index_q[INDEX_W-1:CHUNK_W]};
      if (state_q == LOAD1) begin
        state_d = bus.stream ? STREAM : HOLD;
        done_d  = 1'b1;
        valid_d = 1'b1;
      end else begin
        state_d = LOAD1;
      end
    end else begin
      case (state_q)
        LOAD1:   state_d = bus.stream ? STREAM : HOLD;
        HOLD:    if (bus.stream) state_d = STREAM;
        STREAM: begin
          if (!bus.stream) begin
            state_d = HOLD;
          end else begin
            pre_en = 1'b1;
            if (tick) begin
              index_d = index_q + 1'b1;
              valid_d = 1'b1;
              wrap_d  = &index_q;
            end
          end
        end
        default: state_d = HOLD;
      endcase
    end
    // Any cycle that is not a live stream step restarts the step period.
    pre_clr = !pre_en;
    busy_d  = (state_d == LOAD1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD;
      index_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.index       = index_q;
  assign bus.index_valid = valid_q;
  assign bus.load_done   = done_q;
  assign bus.wrap        = wrap_q;
  assign bus.busy_load   = busy_q;

endmodule

// File: tb/tb_jar_pi_index_ctrl.sv
// Two controllers (step rates 1 and 4) driven in lockstep against a cycle-level reference model.
module tb_jar_pi_index_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  jar_pi_index_ctrl_if bus1 ();
  jar_pi_index_ctrl_if bus4 ();

  jar_pi_index_ctrl #(.PRESCALE(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  jar_pi_index_ctrl #(.PRESCALE(4)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: index value, "first chunk pending", "was streaming",
  // and number of streaming cycles since the step period last restarted.
  int pres [2] = '{1, 4};
  int m_idx [2];
  bit m_half [2];
  bit m_str [2];
  int m_ph [2];
  bit m_valid [2];
  bit m_done [2];
  bit m_wrap [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_half[k] = 0; m_str[k] = 0; m_ph[k] = 0;
      m_valid[k] = 0; m_done[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic model_edge(input bit s, input bit l, input int io);
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_done[k] = 0; m_wrap[k] = 0;
      if (l) begin
        m_idx[k] = (io * 32) + (m_idx[k] / 32);
        if (m_half[k]) begin
          m_done[k] = 1; m_valid[k] = 1; m_half[k] = 0;
        end else begin
          m_half[k] = 1;
        end
        m_ph[k] = 0;
      end else if (m_half[k]) begin
        m_half[k] = 0;
        m_ph[k] = 0;
      end else if (m_str[k] && s) begin
        m_ph[k]++;
        if (m_ph[k] == pres[k]) begin
          m_ph[k] = 0;
          m_wrap[k] = (m_idx[k] == 1023);
          m_idx[k] = (m_idx[k] + 1) % 1024;
          m_valid[k] = 1;
        end
      end else begin
        m_ph[k] = 0;
      end
      m_str[k] = !m_half[k] && s;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/p1 index"}, 32'(bus1.index), m_idx[0]);
    check({tag, "/p1 valid"}, 32'(bus1.index_valid), 32'(m_valid[0]));
    check({tag, "/p1 done"},  32'(bus1.load_done), 32'(m_done[0]));
    check({tag, "/p1 wrap"},  32'(bus1.wrap), 32'(m_wrap[0]));
    check({tag, "/p1 busy"},  32'(bus1.busy_load), 32'(m_half[0]));
    check({tag, "/p4 index"}, 32'(bus4.index), m_idx[1]);
    check({tag, "/p4 valid"}, 32'(bus4.index_valid), 32'(m_valid[1]));
    check({tag, "/p4 done"},  32'(bus4.load_done), 32'(m_done[1]));
    check({tag, "/p4 wrap"},  32'(bus4.wrap), 32'(m_wrap[1]));
    check({tag, "/p4 busy"},  32'(bus4.busy_load), 32'(m_half[1]));
  endtask

  task automatic drive(input bit s, input bit l, input int io);
    bus1.stream = s; bus1.load = l; bus1.io_index = 5'(io);
    bus4.stream = s; bus4.load = l; bus4.io_index = 5'(io);
  endtask

  task automatic cycle(input string tag, input bit s, input bit l, input int io);
    drive(s, l, io);
    @(posedge clk);
    model_edge(s, l, io);
    #1;
    $display("%t %s s=%0b l=%0b io=%0d -> p1 idx=%0d p4 idx=%0d", $time, tag, s, l, io,
             bus1.index, bus4.index);
    check_all(tag);
  endtask

  // Assert reset between clock edges and check outputs clear before any edge.
  task automatic async_reset(input string tag);
    drive(0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    $display("%t %s async reset", $time, tag);
    check_all(tag);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0);
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Stream at full rate
    for (int i = 0; i < 6; i++) cycle("t1", 1, 0, 0);
    check("t1 p1 index", 32'(bus1.index), 5);
    check("t1 p4 index", 32'(bus4.index), 1);
    cycle("t1", 0, 0, 0);

    // Two-chunk load 0x1F then 0x0A
    cycle("t2", 0, 1, 'h1F);
    check("t2 busy", 32'(bus1.busy_load), 1);
    cycle("t2", 0, 1, 'h0A);
    check("t2 index", 32'(bus1.index), 351);
    check("t2 done", 32'(bus1.load_done), 1);
    cycle("t2", 0, 0, 0);
    check("t2 done gone", 32'(bus1.load_done), 0);

    // Load 1022 then stream across the wrap
    cycle("t3", 0, 1, 'h1E);
    cycle("t3", 1, 1, 'h1F);
    check("t3 index", 32'(bus1.index), 1022);
    cycle("t3", 1, 0, 0);
    check("t3 max", 32'(bus1.index), 1023);
    cycle("t3", 1, 0, 0);
    check("t3 zero", 32'(bus1.index), 0);
    check("t3 wrap", 32'(bus1.wrap), 1);
    cycle("t3", 1, 0, 0);
    check("t3 wrap gone", 32'(bus1.wrap), 0);
    cycle("t3", 0, 0, 0);

    // Step rate 4 with a pause mid-period
    for (int i = 0; i < 7; i++) cycle("t4", 1, 0, 0);
    cycle("t4", 0, 0, 0);
    cycle("t4", 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle("t4", 1, 0, 0);
    cycle("t4", 0, 0, 0);

    // Abandoned load from index 0
    async_reset("t5");
    cycle("t5", 0, 1, 'h03);
    cycle("t5", 0, 0, 0);
    check("t5 index", 32'(bus1.index), 'h060);
    check("t5 busy", 32'(bus1.busy_load), 0);

    // Reset between chunks, then a clean load
    cycle("t6", 0, 1, 'h05);
    async_reset("t6");
    cycle("t6", 0, 1, 'h07);
    cycle("t6", 0, 1, 'h09);
    check("t6 index", 32'(bus1.index), 'h09 * 32 + 'h07);

    // Random mix of stream, load and hold
    for (int i = 0; i < 500; i++) begin
      bit s, l;
      int io;
      s  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 5) == 0);
      io = int'($urandom_range(0, 31));
      cycle("rnd", s, l, io);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
